// File: rtl/systolic_input_feeder.sv
// Row FIFO plus diagonal-skew feeder for the west edge of the 2x2 systolic array.
// Optional STREAM-underrun counter is built when SYSTOLIC_FEEDER_UNDERRUN_CNT_EN is defined.
module systolic_input_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data_0,
  input  logic [DATA_WIDTH-1:0] in_data_1,
  input  logic                  in_last,
  input  logic                  go,
  output logic [DATA_WIDTH-1:0] sys_data_in_1x,
  output logic [DATA_WIDTH-1:0] sys_data_in_2x,
  output logic                  sys_start,
  output logic                  busy,
  output logic                  done
`ifdef SYSTOLIC_FEEDER_UNDERRUN_CNT_EN
  ,
  output logic [7:0]            underrun_count
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 2 * DATA_WIDTH + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [EW-1:0]           mem_q [DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q, count_d;
  logic                    in_ready_q;
  logic [DATA_WIDTH-1:0]   d1x_q, d2x_q, skew_q;
  logic                    start_q, busy_q, done_q;
  logic                    push, pop, empty;
  logic [EW-1:0]           rd_entry;

  // in_ready comes straight from a register, so a pop never opens the door for a same-cycle push.
  assign push     = in_valid && in_ready_q;
  assign empty    = (count_q == '0);
  assign rd_entry = mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (go && !empty) state_d = STREAM;
      end
      STREAM: begin
        if (!empty) begin
          pop = 1'b1;
          if (rd_entry[EW-1]) state_d = DRAIN;
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_last, in_data_1, in_data_0};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
      d1x_q      <= '0;
      d2x_q      <= '0;
      skew_q     <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      in_ready_q <= (count_d != FULL_CNT);
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      start_q    <= pop;
      d1x_q      <= pop ? rd_entry[DATA_WIDTH-1:0] : '0;
      // Lane 2 trails lane 1 by one cycle; zero flows through when no row was popped.
      skew_q     <= pop ? rd_entry[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
      d2x_q      <= skew_q;
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_q == DRAIN);
    end
  end

  assign in_ready       = in_ready_q;
  assign sys_data_in_1x = d1x_q;
  assign sys_data_in_2x = d2x_q;
  assign sys_start      = start_q;
  assign busy           = busy_q;
  assign done           = done_q;

`ifdef SYSTOLIC_FEEDER_UNDERRUN_CNT_EN
  logic [7:0] underrun_q;
  logic       go_accept, underrun;

  assign go_accept = (state_q == IDLE) && go && !empty;
  assign underrun  = (state_q == STREAM) && empty;

  always_ff @(posedge clk) begin
    if (!rst || go_accept) begin
      underrun_q <= '0;
    end else if (underrun && (underrun_q != 8'hFF)) begin
      underrun_q <= underrun_q + 8'd1;
    end
  end

  assign underrun_count = underrun_q;
`endif

endmodule

// File: doc/systolic_input_feeder.md
Name: systolic_input_feeder

Overview:
- Upstream stage of the 2x2 systolic array. It buffers activation rows from the unified-buffer read path and streams them into the array's west edge with diagonal skew.
- Lane 1 is presented one cycle before lane 2. It drives sys_data_in_1x, sys_data_in_2x and sys_start (the valid that enters pe11 and ripples east/south).
- It signals tile completion so the control FSM can issue the next weight switch.

Parameters:
- DATA_WIDTH, 16, width of each activation element (fixed-point, passed through unmodified).
- DEPTH, 8, row FIFO depth in rows; must be a power of two, >= 2.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-low (0 = reset).
- in_valid  input  1  upstream row valid.
- in_ready  output  1  FIFO can accept a row.
- in_data_0  input  DATA_WIDTH  row element for array row 1.
- in_data_1  input  DATA_WIDTH  row element for array row 2.
- in_last  input  1  marks the final row of the current tile.
- go  input  1  start-streaming pulse; sampled only in IDLE.
- sys_data_in_1x  output  DATA_WIDTH  to array row 1.
- sys_data_in_2x  output  DATA_WIDTH  to array row 2 (skewed +1 cycle).
- sys_start  output  1  valid for the lane-1 element this cycle.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse at tile completion.

Behaviour:
- Reset (rst=0 at a clock edge):
  - FIFO empties (pointers 0).
  - State goes to IDLE.
  - All outputs 0 except in_ready=1.
  - Reset mid-stream aborts the tile; no done pulse; the skew register clears.
- Handshake and FIFO:
  - A push occurs when in_valid && in_ready. The entry stores {in_last, in_data_1, in_data_0}.
  - in_ready = !full, registered from occupancy. There is no combinational path from pop to in_ready. At full, a simultaneous pop does not admit a push that cycle.
  - Pushes are accepted in every state.
  - Occupancy counter is 0..DEPTH. Pointers wrap modulo DEPTH.
- FSM IDLE -> STREAM -> DRAIN -> IDLE:
  - IDLE: on go=1 with the FIFO non-empty, go to STREAM. go with the FIFO empty is ignored. go outside IDLE is ignored.
  - STREAM: each cycle with the FIFO non-empty, pop one row.
    - Next cycle: sys_data_in_1x = d0, sys_start = 1, and d1 is captured into the skew register.
    - One cycle after that: sys_data_in_2x = d1. Lane-1 latency from pop is 1; lane-2 latency is 2.
    - Underrun (FIFO empty in STREAM): no pop. The next cycle has sys_start=0 and sys_data_in_1x=0 (bubble). Lane 2 still emits the previously skewed element. The FSM remains in STREAM.
    - On popping a row with last=1, go to DRAIN.
  - DRAIN (1 cycle): no pop. sys_start=0, sys_data_in_1x=0, and lane 2 emits the final skewed element. Then go to IDLE with done=1 for exactly one cycle, on the cycle the FSM enters IDLE.
  - Rows pushed after the last row of a tile stay queued for the next go.
- Output timing:
  - sys_data_in_2x is 0 whenever it carries no skewed element.
  - All outputs are registered.
- Single-row tile: a push with last=1, then go. Results: sys_start is high for 1 cycle; lane 2 is valid the following cycle; done follows.

Optional Feature:
- Macro: SYSTOLIC_FEEDER_UNDERRUN_CNT_EN.
- With the macro defined:
  - Extra output port underrun_count (output, 8 bits).
  - The counter increments on each STREAM underrun bubble and saturates at 255.
  - It clears on reset and when go is accepted.
- Without the macro: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1 -> in_ready=1, busy=0, done=0, sys_start=0, all data 0; no push recorded (first go after release is ignored).
- Basic skew: push rows (1,2), (3,4), (5,6 last), then go -> sys_data_in_1x=1,3,5 on cycles go+2..go+4 with sys_start=1; sys_data_in_2x=2,4,6 on go+3..go+5; done on go+5.
- Full FIFO: push 8 rows with no go -> in_ready=0 after the 8th. A ninth row held at in_valid is not accepted. After go, in_ready returns to 1 one cycle after the first pop, and all 9 rows emerge in order.
- Underrun: push (7,8), go, then push (9,10 last) 3 cycles later -> sys_start shows a 1,0,0,1 pattern with zero lane-1 data in the bubbles. Lane 2 emits 8 then 10 with correct skew. The underrun_count = 2 under the macro.
- Back-to-back tiles: push (1,1 last), (2,2 last), go, wait for done, go again -> two separate tiles, each with its own done pulse; go during busy has no effect.
- Reset mid-stream: rst=0 on the cycle after the second pop of a 4-row tile -> next cycle all outputs are 0, no done, and the FIFO is empty.
